fetch_stage: RTL

Instruction-fetch stage of the pipelined RISC-V core. Holds the PC register, selects the next PC from the EX-stage redirect code (`pcsrce`, produced by the jump/branch resolver), and drives the IF/ID pipeline register. Generates the flush requests that squash wrong-path instructions in ID and EX. Sits between instruction memory and the decode stage; stall requests come from the hazard unit.

---
 rtl/riscv_pkg.sv | 11 +
 rtl/fetch_stage_if.sv | 31 +++
 rtl/if_id_reg.sv | 36 +++
 rtl/fetch_stage.sv | 73 +++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared core definitions: NOP encoding and the EX-stage PC-source codes
// (also used by the jump/branch resolver).
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;  // addi x0, x0, 0

    localparam logic [1:0]  PCSRC_PLUS4  = 2'b00;
    localparam logic [1:0]  PCSRC_TARGET = 2'b01;
    localparam logic [1:0]  PCSRC_ALU    = 2'b10;

endpackage

// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage and its neighbours: EX redirect,
// hazard-unit stalls, instruction memory and the IF/ID outputs.
interface fetch_stage_if #(
    parameter int XLEN = 32
);
    logic [1:0]      pcsrce;
    logic [XLEN-1:0] pctargete;
    logic [XLEN-1:0] aluresulte;
    logic            stallf;
    logic            stalld;
    logic [31:0]     instrf;
    logic [XLEN-1:0] pcf;
    logic [31:0]     instrd;
    logic [XLEN-1:0] pcd;
    logic [XLEN-1:0] pcplus4d;
    logic            validd;
    logic            flushd;
    logic            flushe;

    // Surrounding pipeline / memory side
    modport master (
        output pcsrce, pctargete, aluresulte, stallf, stalld, instrf,
        input  pcf, instrd, pcd, pcplus4d, validd, flushd, flushe
    );

    // Fetch stage side
    modport slave (
        input  pcsrce, pctargete, aluresulte, stallf, stalld, instrf,
        output pcf, instrd, pcd, pcplus4d, validd, flushd, flushe
    );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: synchronous clear (reset or squash) beats
// enable; clearing inserts a NOP that is marked invalid.
module if_id_reg #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] CLR_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] pcplus4,
    input  logic            valid,
    output logic [31:0]     instr_q,
    output logic [XLEN-1:0] pc_q,
    output logic [XLEN-1:0] pcplus4_q,
    output logic            valid_q
);

    // Priority: reset/clear, then hold when not enabled, else load
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            instr_q   <= CLR_INSTR;
            pc_q      <= '0;
            pcplus4_q <= '0;
            valid_q   <= 1'b0;
        end else if (en) begin
            instr_q   <= instr;
            pc_q      <= pc;
            pcplus4_q <= pcplus4;
            valid_q   <= valid;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC select from the EX redirect
// code, flush generation and the IF/ID register.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.slave  bus
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pcplus4f;
    logic [XLEN-1:0] next_pc;
    logic            redirect;

    assign pcplus4f = pc_q + XLEN'(4);

    // Decode the redirect code into a next-PC; code 11 falls back to PC+4
    always_comb begin
        redirect = 1'b0;
        next_pc  = pcplus4f;
        case (bus.pcsrce)
            PCSRC_PLUS4: begin
                redirect = 1'b0;
                next_pc  = pcplus4f;
            end
            PCSRC_TARGET: begin
                redirect = 1'b1;
                next_pc  = bus.pctargete;
            end
            PCSRC_ALU: begin
                redirect = 1'b1;
                next_pc  = {bus.aluresulte[XLEN-1:1], 1'b0};  // JALR clears bit 0
            end
            default: ;
        endcase
    end

    // PC register; a redirect overrides stallf
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (redirect || !bus.stallf) begin
            pc_q <= next_pc;
        end
    end

    assign bus.pcf    = pc_q;
    assign bus.flushd = redirect && !rst;
    assign bus.flushe = redirect && !rst;

    if_id_reg #(
        .XLEN      (XLEN),
        .CLR_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk       (clk),
        .rst       (rst),
        .clr       (redirect),
        .en        (!bus.stalld),
        .instr     (bus.instrf),
        .pc        (pc_q),
        .pcplus4   (pcplus4f),
        .valid     (1'b1),
        .instr_q   (bus.instrd),
        .pc_q      (bus.pcd),
        .pcplus4_q (bus.pcplus4d),
        .valid_q   (bus.validd)
    );

endmodule
